// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - per-stage stall/flush/halt arbitration, valid tracking and retire counting
// Optional perf counters for stall/flush cycles are built when PIPE_PERF_EN is defined.
module pipe_flow_ctrl #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic [STAGES-1:0] stall_req,
    input  logic [STAGES-1:0] flush_req,
    input  logic              halt_req,
    input  logic              GO,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state;
    logic              go_q;
    logic              go_rise;
    logic              stall_any;
    logic              flush_any;
    int                stall_idx;
    int                flush_idx;
    logic              running;
    logic              halt_fire;
    logic              stall_win;
    logic              flush_win;
    logic              retire;
    logic [STAGES-1:0] valid_shift;
    logic [STAGES-1:0] valid_next;

    assign go_rise = GO & ~go_q;
    assign running = (state == ST_RUN);

    // Oldest (highest-numbered) valid requester of each kind decides the response.
    always_comb begin
        stall_any = 1'b0;
        flush_any = 1'b0;
        stall_idx = 0;
        flush_idx = 0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_req[i] && valid[i]) begin
                stall_any = 1'b1;
                stall_idx = i;
            end
            if (flush_req[i] && valid[i]) begin
                flush_any = 1'b1;
                flush_idx = i;
            end
        end
    end

    assign halt_fire = running && halt_req && valid[STAGES-1];
    assign stall_win = running && !halt_fire && stall_any &&
                       (!flush_any || (stall_idx >= flush_idx));
    assign flush_win = running && !halt_fire && flush_any && !stall_win;
    assign retire    = running && valid[STAGES-1];

    // Fetch always brings in a fresh instruction when it advances.
    assign valid_shift = {valid[STAGES-2:0], 1'b1};

    always_comb begin
        stage_en   = '0;
        bubble     = '0;
        valid_next = valid;
        if (running) begin
            if (halt_fire) begin
                // Freeze everything; the halting instruction retires out of writeback.
                valid_next[STAGES-1] = 1'b0;
            end else if (stall_win) begin
                for (int i = 0; i < STAGES; i++) begin
                    if (i <= stall_idx) begin
                        stage_en[i]   = 1'b0;
                        valid_next[i] = valid[i];
                    end else if (i == stall_idx + 1) begin
                        stage_en[i]   = 1'b1;
                        bubble[i]     = 1'b1;
                        valid_next[i] = 1'b0;
                    end else begin
                        stage_en[i]   = 1'b1;
                        valid_next[i] = valid_shift[i];
                    end
                end
            end else if (flush_win) begin
                stage_en = '1;
                for (int i = 0; i < STAGES; i++) begin
                    if (i >= 1 && i <= flush_idx) begin
                        bubble[i]     = 1'b1;
                        valid_next[i] = 1'b0;
                    end else begin
                        valid_next[i] = valid_shift[i];
                    end
                end
            end else begin
                stage_en   = '1;
                valid_next = valid_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            valid      <= {{(STAGES-1){1'b0}}, 1'b1};
            retire_cnt <= '0;
            go_q       <= 1'b0;
        end else begin
            go_q  <= GO;
            valid <= valid_next;
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (halt_fire) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (go_rise) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (CLR) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_win) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_win) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - scoreboard bench for pipe_flow_ctrl (STAGES=5)
module tb_pipe_flow_ctrl;

    localparam int STAGES = 5;
    localparam int CNT_W  = 32;
`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk;
    logic              CLR;
    logic [STAGES-1:0] stall_req;
    logic [STAGES-1:0] flush_req;
    logic              halt_req;
    logic              GO;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] valid;
    logic              halted;
    logic [CNT_W-1:0]  retire_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    typedef struct packed {
        logic [STAGES-1:0] en;
        logic [STAGES-1:0] bub;
        logic [STAGES-1:0] vld;
        logic              hlt;
        logic [CNT_W-1:0]  ret;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    pipe_flow_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .CLR        (CLR),
        .stall_req  (stall_req),
        .flush_req  (flush_req),
        .halt_req   (halt_req),
        .GO         (GO),
        .stage_en   (stage_en),
        .bubble     (bubble),
        .valid      (valid),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show before the next edge.
    task automatic step(input logic [4:0] st, input logic [4:0] fl, input logic h, input logic g,
                        input logic c, input logic [4:0] e_en, input logic [4:0] e_bub,
                        input logic [4:0] e_vld, input logic e_hlt, input int e_ret,
                        input int e_sc, input int e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        stall_req = st;
        flush_req = fl;
        halt_req  = h;
        GO        = g;
        CLR       = c;
        e.en  = e_en;
        e.bub = e_bub;
        e.vld = e_vld;
        e.hlt = e_hlt;
        e.ret = CNT_W'(e_ret);
        e.sc  = PERF ? CNT_W'(e_sc) : '0;
        e.fc  = PERF ? CNT_W'(e_fc) : '0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_no++;
            check_val("stage_en",   64'(stage_en),   64'(e.en));
            check_val("bubble",     64'(bubble),     64'(e.bub));
            check_val("valid",      64'(valid),      64'(e.vld));
            check_val("halted",     64'(halted),     64'(e.hlt));
            check_val("retire_cnt", 64'(retire_cnt), 64'(e.ret));
            check_val("stall_cnt",  64'(stall_cnt),  64'(e.sc));
            check_val("flush_cnt",  64'(flush_cnt),  64'(e.fc));
        end
    end

    initial begin
        CLR = 1'b1; stall_req = '0; flush_req = '0; halt_req = 1'b0; GO = 1'b0;
        repeat (2) @(posedge clk);
        //     stall     flush     h  g  c  en        bub       valid     hlt ret sc fc
        // reset state, then fill
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00001, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00011, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00111, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b01111, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 1,  0, 0);
        // load-use stall at ID
        step(5'b00010, 5'b00000, 0, 0, 0, 5'b11100, 5'b00100, 5'b11111, 0, 2,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11011, 0, 3,  1, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b10111, 0, 4,  1, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b01111, 0, 5,  1, 0);
        // branch flush at EX
        step(5'b00000, 5'b00100, 0, 0, 0, 5'b11111, 5'b00110, 5'b11111, 0, 5,  1, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11001, 0, 6,  1, 1);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b10011, 0, 7,  1, 1);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00111, 0, 8,  1, 1);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b01111, 0, 8,  1, 1);
        // older flush beats younger stall
        step(5'b00010, 5'b00100, 0, 0, 0, 5'b11111, 5'b00110, 5'b11111, 0, 8,  1, 1);
        // stall request on an invalid stage is ignored
        step(5'b00100, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11001, 0, 9,  1, 2);
        // flush from writeback squashes every younger stage
        step(5'b00000, 5'b10000, 0, 0, 0, 5'b11111, 5'b11110, 5'b10011, 0, 10, 1, 2);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00001, 0, 11, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00011, 0, 11, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00111, 0, 11, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b01111, 0, 11, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111, 0, 11, 1, 3);
        // syscall halt, then GO held high for 4 cycles
        step(5'b00000, 5'b00000, 1, 0, 0, 5'b00000, 5'b00000, 5'b11111, 0, 12, 1, 3);
        step(5'b00000, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 5'b01111, 1, 13, 1, 3);
        step(5'b00000, 5'b00000, 0, 1, 0, 5'b11111, 5'b00000, 5'b01111, 0, 13, 1, 3);
        step(5'b00000, 5'b00000, 1, 1, 0, 5'b00000, 5'b00000, 5'b11111, 0, 13, 1, 3);
        step(5'b00010, 5'b00100, 0, 1, 0, 5'b00000, 5'b00000, 5'b01111, 1, 14, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b00000, 5'b00000, 5'b01111, 1, 14, 1, 3);
        step(5'b00000, 5'b00000, 0, 1, 0, 5'b00000, 5'b00000, 5'b01111, 1, 14, 1, 3);
        // halt without a valid writeback instruction is ignored
        step(5'b00000, 5'b00000, 1, 0, 0, 5'b11111, 5'b00000, 5'b01111, 0, 14, 1, 3);
        step(5'b00000, 5'b00000, 1, 0, 0, 5'b00000, 5'b00000, 5'b11111, 0, 14, 1, 3);
        // reset while halted
        step(5'b00000, 5'b00000, 0, 0, 1, 5'b00000, 5'b00000, 5'b01111, 1, 15, 1, 3);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00001, 0, 0,  0, 0);
        step(5'b00000, 5'b00000, 0, 0, 0, 5'b11111, 5'b00000, 5'b00011, 0, 0,  0, 0);
        @(posedge clk);
        @(posedge clk);
        check_val("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
